// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and grant identifiers for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2,
    RESP     = 2'd3
  } state_t;
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker favouring the side that did not win last
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic last_grant,
  output logic any,
  output logic pick
);
  // On a tie the loser of the previous grant wins; otherwise the only requester wins
  always_comb begin
    any  = ic_valid | dc_valid;
    pick = (ic_valid && dc_valid) ? ~last_grant : (dc_valid ? GNT_DC : GNT_IC);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache reads and D-cache reads/writes
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_valid,
  output logic [DATA_W-1:0] ic_req_data,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_wr,
  input  logic [DATA_W-1:0] dc_wr_data,
  input  logic              dc_req_valid,
  output logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic              timeout_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);
  state_t state, state_nx;
  logic last_grant, any, pick, in_grant;
  logic [CW-1:0] wd_cnt, wd_nx;
  rr_pick2 u_pick (
    .ic_valid  (ic_req_valid),
    .dc_valid  (dc_req_valid),
    .last_grant(last_grant),
    .any       (any),
    .pick      (pick)
  );
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // Next state plus saturating watchdog increment
  always_comb begin
    in_grant = (state == GRANT_IC) || (state == GRANT_DC);
    wd_nx    = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CW'(1);
    state_nx = state;
    if (state == IDLE && any) state_nx = (pick == GNT_IC) ? GRANT_IC : GRANT_DC;
    else if (in_grant && mem_req_ready) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
  end
  // Registered request launch, completion capture and sticky watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= GNT_DC;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
      ic_req_data   <= '0;
      ic_req_ready  <= 1'b0;
      dc_req_data   <= '0;
      dc_req_ready  <= 1'b0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
    end else begin
      ic_req_ready <= 1'b0;
      dc_req_ready <= 1'b0;
      if (state == IDLE && any) begin
        last_grant    <= pick;
        wd_cnt        <= '0;
        mem_req_valid <= 1'b1;
        mem_req_addr  <= (pick == GNT_IC) ? ic_req_addr : dc_req_addr;
        mem_req_wr    <= (pick == GNT_IC) ? 1'b0 : dc_req_wr;
        mem_wr_data   <= (pick == GNT_IC) ? '0 : dc_wr_data;
      end
      if (in_grant && mem_req_ready) begin
        mem_req_valid <= 1'b0;
        mem_req_wr    <= 1'b0;
        if (state == GRANT_IC) begin
          ic_req_ready <= 1'b1;
          ic_req_data  <= mem_req_data;
        end else begin
          dc_req_ready <= 1'b1;
          if (!mem_req_wr) dc_req_data <= mem_req_data;
        end
      end else if (in_grant) begin
        wd_cnt <= wd_nx;
        if (TIMEOUT != 0 && wd_nx == WD_MAX) timeout_err <= 1'b1;
      end
    end
  end
endmodule
